// File: rtl/cpu_trace_tx_pkg.sv
// Package: cpu_trace_tx_pkg
// Purpose: shared constants, types and helpers for the CPU trace UART exporter.
//   - ASCII punctuation used in the trace line
//   - frame lengths with and without the memory-update suffix
//   - top-level FSM state encoding
//   - hex_ascii(): nibble -> uppercase ASCII hex digit
package cpu_trace_tx_pkg;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  // "PP IIII IIII IIII IIII IIII" + CRLF, optionally + " AA:DDDD"
  localparam int FRAME_LEN_BASE = 29;
  localparam int FRAME_LEN_MEM  = 37;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10)
      return 8'h30 + {4'h0, nib};
    else
      return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/cpu_trace_tx_uart_tx_8n1.sv
// Module: uart_tx_8n1
// Purpose: 8N1 UART transmitter, LSB first, one character per start pulse.
// Ports:
//   CLK    in   system clock
//   RST    in   asynchronous active-high reset (tx forced high)
//   start  in   load data and begin a character; honoured only when ready=1
//   data   in   8-bit character
//   tx     out  serial line, idle high
//   ready  out  idle, or in the last cycle of the stop bit (allows back-to-back chars)
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] baud_cnt_reg;
  logic [3:0]    bit_idx_reg;
  logic [9:0]    shift_reg;
  logic          active_reg;
  logic          last_tick;

  assign last_tick = (baud_cnt_reg == CW'(CLKS_PER_BIT - 1));
  assign ready     = !active_reg || (last_tick && bit_idx_reg == 4'd9);

  // The line is the LSB of the shift register; shifting in ones leaves it
  // idle-high once the stop bit has gone out, and reset to all ones makes tx
  // high as soon as RST asserts.
  assign tx = shift_reg[0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '1;
      active_reg   <= 1'b0;
    end else if (start && ready) begin
      shift_reg    <= {1'b1, data, 1'b0};
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      active_reg   <= 1'b1;
    end else if (active_reg) begin
      if (last_tick) begin
        baud_cnt_reg <= '0;
        shift_reg    <= {1'b1, shift_reg[9:1]};
        if (bit_idx_reg == 4'd9)
          active_reg <= 1'b0;
        else
          bit_idx_reg <= bit_idx_reg + 4'd1;
      end else begin
        baud_cnt_reg <= baud_cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_trace_tx.sv
// Module: cpu_trace_tx
// Purpose: latch one CPU pipeline snapshot on snap and send it as an ASCII
//   hex line "PP IIII IIII IIII IIII IIII[ AA:DDDD]\r\n" over an 8N1 UART.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   snap                     one-cycle snapshot request
//   pc, *_insn               PC and the IF/ID/EX/MEM/WB instructions
//   memupdate/memaddr/memdata optional data-memory update appended to the line
//   tx                       UART serial output, idle high
//   busy                     frame in progress; snap is dropped while high
//   overrun_cnt              saturating count of dropped snaps
module cpu_trace_tx
  import cpu_trace_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        snap,
  input  logic [7:0]  pc,
  input  logic [15:0] if_insn,
  input  logic [15:0] id_insn,
  input  logic [15:0] ex_insn,
  input  logic [15:0] mem_insn,
  input  logic [15:0] wb_insn,
  input  logic        memupdate,
  input  logic [7:0]  memaddr,
  input  logic [15:0] memdata,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  // Index of the CR when no memory suffix is present.
  localparam logic [5:0] TAIL_IDX = 6'(FRAME_LEN_BASE - 2);

  state_t      state_reg;
  logic        busy_reg;
  logic [7:0]  overrun_cnt_reg;
  logic [7:0]  pc_reg;
  logic [15:0] insn_reg [5];
  logic        memupdate_reg;
  logic [7:0]  memaddr_reg;
  logic [15:0] memdata_reg;
  logic [5:0]  char_idx_reg;
  logic        start_reg;

  logic [7:0]  frame_chars [64];
  logic [7:0]  char_data;
  logic [5:0]  last_idx;
  logic        uart_ready;

  // Character table laid out for the long (memory-update) frame; the short
  // frame reuses the first 27 entries and swaps CRLF in at TAIL_IDX.
  assign frame_chars[0] = hex_ascii(pc_reg[7:4]);
  assign frame_chars[1] = hex_ascii(pc_reg[3:0]);

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
      assign frame_chars[2 + gi*5] = SPACE;
      assign frame_chars[3 + gi*5] = hex_ascii(insn_reg[gi][15:12]);
      assign frame_chars[4 + gi*5] = hex_ascii(insn_reg[gi][11:8]);
      assign frame_chars[5 + gi*5] = hex_ascii(insn_reg[gi][7:4]);
      assign frame_chars[6 + gi*5] = hex_ascii(insn_reg[gi][3:0]);
    end
    for (genvar gi = FRAME_LEN_MEM; gi < 64; gi++) begin : g_unused
      assign frame_chars[gi] = 8'h00;
    end
  endgenerate

  assign frame_chars[27] = SPACE;
  assign frame_chars[28] = hex_ascii(memaddr_reg[7:4]);
  assign frame_chars[29] = hex_ascii(memaddr_reg[3:0]);
  assign frame_chars[30] = COLON;
  assign frame_chars[31] = hex_ascii(memdata_reg[15:12]);
  assign frame_chars[32] = hex_ascii(memdata_reg[11:8]);
  assign frame_chars[33] = hex_ascii(memdata_reg[7:4]);
  assign frame_chars[34] = hex_ascii(memdata_reg[3:0]);
  assign frame_chars[35] = CR;
  assign frame_chars[36] = LF;

  always_comb begin
    char_data = frame_chars[char_idx_reg];
    if (!memupdate_reg && char_idx_reg == TAIL_IDX)
      char_data = CR;
    if (!memupdate_reg && char_idx_reg == TAIL_IDX + 6'd1)
      char_data = LF;
  end

  assign last_idx    = memupdate_reg ? 6'(FRAME_LEN_MEM - 1) : 6'(FRAME_LEN_BASE - 1);
  assign busy        = busy_reg;
  assign overrun_cnt = overrun_cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg       <= ST_IDLE;
      busy_reg        <= 1'b0;
      overrun_cnt_reg <= '0;
      pc_reg          <= '0;
      for (int i = 0; i < 5; i++) insn_reg[i] <= '0;
      memupdate_reg   <= 1'b0;
      memaddr_reg     <= '0;
      memdata_reg     <= '0;
      char_idx_reg    <= '0;
      start_reg       <= 1'b0;
    end else begin
      if (snap && busy_reg && overrun_cnt_reg != 8'hFF)
        overrun_cnt_reg <= overrun_cnt_reg + 8'd1;

      case (state_reg)
        ST_IDLE: begin
          if (snap) begin
            pc_reg        <= pc;
            insn_reg[0]   <= if_insn;
            insn_reg[1]   <= id_insn;
            insn_reg[2]   <= ex_insn;
            insn_reg[3]   <= mem_insn;
            insn_reg[4]   <= wb_insn;
            memupdate_reg <= memupdate;
            memaddr_reg   <= memaddr;
            memdata_reg   <= memdata;
            busy_reg      <= 1'b1;
            state_reg     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          char_idx_reg <= '0;
          start_reg    <= 1'b1;
          state_reg    <= ST_SEND;
        end
        ST_SEND: begin
          // start stays asserted while characters remain, so the UART picks
          // up the next one in the last stop-bit cycle with no idle gap.
          if (start_reg) begin
            if (uart_ready) begin
              if (char_idx_reg == last_idx)
                start_reg <= 1'b0;
              else
                char_idx_reg <= char_idx_reg + 6'd1;
            end
          end else if (uart_ready) begin
            // ready with nothing queued = last cycle of the final stop bit
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .CLK  (CLK),
    .RST  (RST),
    .start(start_reg),
    .data (char_data),
    .tx   (tx),
    .ready(uart_ready)
  );

endmodule
